// File: rtl/hci_core_merge.sv
// Merges NB_IN_CHAN narrow TCDM requesters into one wide memory-side port.
// Each channel parks one request; the wide access issues once all channels hold one.
`timescale 1ns/1ps

module hci_core_merge #(
   parameter int DW         = 64,
   parameter int NB_IN_CHAN = 2,
   parameter int AW         = 32,
   parameter int UW         = 4,
   parameter int BOW        = 16,
   parameter int OW         = 1,
   localparam int DW_IN     = DW / NB_IN_CHAN,
   localparam int BW_IN     = DW_IN / 8
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 clear_i,

   input  logic [NB_IN_CHAN-1:0]                i_slvReq,
   input  logic [NB_IN_CHAN-1:0][AW-1:0]        i_slvAdd,
   input  logic [NB_IN_CHAN-1:0]                i_slvWen,
   input  logic [NB_IN_CHAN-1:0][BW_IN-1:0]     i_slvBe,
   input  logic [NB_IN_CHAN-1:0][DW_IN-1:0]     i_slvData,
   input  logic [NB_IN_CHAN-1:0]                i_slvLrdy,
   output logic [NB_IN_CHAN-1:0]                o_slvGnt,
   output logic [NB_IN_CHAN-1:0]                o_slvRValid,
   output logic [NB_IN_CHAN-1:0][DW_IN-1:0]     o_slvRData,
   output logic [NB_IN_CHAN-1:0][OW-1:0]        o_slvROpc,
   output logic [NB_IN_CHAN-1:0][UW-1:0]        o_slvRUser,

   output logic                                 o_mstReq,
   input  logic                                 i_mstGnt,
   output logic [AW-1:0]                        o_mstAdd,
   output logic                                 o_mstWen,
   output logic [DW/8-1:0]                      o_mstBe,
   output logic [DW-1:0]                        o_mstData,
   output logic [BOW-1:0]                       o_mstBoffs,
   output logic [UW-1:0]                        o_mstUser,
   output logic                                 o_mstLrdy,
   input  logic                                 i_mstRValid,
   input  logic [DW-1:0]                        i_mstRData,
   input  logic [OW-1:0]                        i_mstROpc
);

   typedef enum logic [1:0] {
      COLLECT,
      ISSUE,
      RESP
   } state_t;

   state_t                               r_state;
   state_t                               w_stateNext;

   logic [NB_IN_CHAN-1:0]                r_full;
   logic [NB_IN_CHAN-1:0]                w_fullNext;
   logic [NB_IN_CHAN-1:0]                w_capture;
   logic                                 w_allFullNext;
   logic                                 w_issueAccept;
   logic                                 w_respActive;

   logic [NB_IN_CHAN-1:0][AW-1:0]        r_bufAdd;
   logic [NB_IN_CHAN-1:0]                r_bufWen;
   logic [NB_IN_CHAN-1:0][BW_IN-1:0]     r_bufBe;
   logic [NB_IN_CHAN-1:0][DW_IN-1:0]     r_bufData;

   // A channel can only be granted while its buffer is empty, so the
   // post-edge occupancy is simply the current occupancy OR the request.
   assign o_slvGnt      = ~r_full;
   assign w_capture     = i_slvReq & ~r_full;
   assign w_fullNext    = r_full | w_capture;
   assign w_allFullNext = &w_fullNext;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= COLLECT;
      end else if (clear_i) begin
         r_state <= COLLECT;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      unique case (r_state)
         COLLECT: begin
            if (w_allFullNext) begin
               w_stateNext = ISSUE;
            end
         end
         ISSUE: begin
            if (i_mstGnt) begin
               w_stateNext = RESP;
            end
         end
         RESP: begin
            if (i_mstRValid) begin
               w_stateNext = w_allFullNext ? ISSUE : COLLECT;
            end
         end
         default: w_stateNext = COLLECT;
      endcase
   end

   always_comb begin
      o_mstReq      = 1'b0;
      w_issueAccept = 1'b0;
      w_respActive  = 1'b0;
      unique case (r_state)
         ISSUE: begin
            o_mstReq      = 1'b1;
            w_issueAccept = i_mstGnt;
         end
         RESP: begin
            w_respActive = 1'b1;
         end
         default: begin
            o_mstReq = 1'b0;
         end
      endcase
   end

   // Buffers drain together when the wide access is granted; no channel is
   // granted in that cycle because every buffer is still full.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_full <= '0;
      end else if (clear_i) begin
         r_full <= '0;
      end else if (w_issueAccept) begin
         r_full <= '0;
      end else begin
         r_full <= w_fullNext;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_bufAdd  <= '0;
         r_bufWen  <= '0;
         r_bufBe   <= '0;
         r_bufData <= '0;
      end else if (clear_i) begin
         r_bufAdd  <= '0;
         r_bufWen  <= '0;
         r_bufBe   <= '0;
         r_bufData <= '0;
      end else begin
         for (int i = 0; i < NB_IN_CHAN; i++) begin
            if (w_capture[i]) begin
               r_bufAdd[i]  <= i_slvAdd[i];
               r_bufWen[i]  <= i_slvWen[i];
               r_bufBe[i]   <= i_slvBe[i];
               r_bufData[i] <= i_slvData[i];
            end
         end
      end
   end

   // Channel 0 supplies address and direction; the others are not cross-checked.
   assign o_mstAdd   = r_bufAdd[0];
   assign o_mstWen   = r_bufWen[0];
   assign o_mstBe    = r_bufBe;
   assign o_mstData  = r_bufData;
   assign o_mstBoffs = '0;
   assign o_mstUser  = '0;
   assign o_mstLrdy  = &i_slvLrdy;

   generate
      for (genvar g = 0; g < NB_IN_CHAN; g++) begin : g_resp
         assign o_slvRValid[g] = i_mstRValid & w_respActive;
         assign o_slvRData[g]  = i_mstRData[(g+1)*DW_IN-1 : g*DW_IN];
         assign o_slvROpc[g]   = i_mstROpc;
         assign o_slvRUser[g]  = '0;
      end
      if (NB_IN_CHAN > 1) begin : g_unusedHi
         logic w_unusedHiBits;
         assign w_unusedHiBits = ^{r_bufAdd[NB_IN_CHAN-1:1], r_bufWen[NB_IN_CHAN-1:1]};
      end
   endgenerate

endmodule

// File: tb/tb_hci_core_merge.sv
// Bench for hci_core_merge: directed scenarios then random traffic, all checked
// every cycle against a transaction-level model of buffered channels.
`timescale 1ns/1ps

module tb_hci_core_merge;

   localparam int DW    = 64;
   localparam int NB    = 2;
   localparam int AW    = 32;
   localparam int UW    = 4;
   localparam int BOW   = 16;
   localparam int OW    = 1;
   localparam int DWIN  = DW / NB;
   localparam int BWIN  = DWIN / 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                      rstN;
   logic                      clear;
   logic [NB-1:0]             slvReq;
   logic [NB-1:0][AW-1:0]     slvAdd;
   logic [NB-1:0]             slvWen;
   logic [NB-1:0][BWIN-1:0]   slvBe;
   logic [NB-1:0][DWIN-1:0]   slvData;
   logic [NB-1:0]             slvLrdy;
   logic [NB-1:0]             slvGnt;
   logic [NB-1:0]             slvRValid;
   logic [NB-1:0][DWIN-1:0]   slvRData;
   logic [NB-1:0][OW-1:0]     slvROpc;
   logic [NB-1:0][UW-1:0]     slvRUser;
   logic                      mstReq;
   logic                      mstGnt;
   logic [AW-1:0]             mstAdd;
   logic                      mstWen;
   logic [DW/8-1:0]           mstBe;
   logic [DW-1:0]             mstData;
   logic [BOW-1:0]            mstBoffs;
   logic [UW-1:0]             mstUser;
   logic                      mstLrdy;
   logic                      mstRValid;
   logic [DW-1:0]             mstRData;
   logic [OW-1:0]             mstROpc;

   hci_core_merge #(.DW(DW), .NB_IN_CHAN(NB), .AW(AW), .UW(UW), .BOW(BOW), .OW(OW)) dut (
      .clk_i(clk), .rst_ni(rstN), .clear_i(clear),
      .i_slvReq(slvReq), .i_slvAdd(slvAdd), .i_slvWen(slvWen), .i_slvBe(slvBe),
      .i_slvData(slvData), .i_slvLrdy(slvLrdy), .o_slvGnt(slvGnt), .o_slvRValid(slvRValid),
      .o_slvRData(slvRData), .o_slvROpc(slvROpc), .o_slvRUser(slvRUser),
      .o_mstReq(mstReq), .i_mstGnt(mstGnt), .o_mstAdd(mstAdd), .o_mstWen(mstWen),
      .o_mstBe(mstBe), .o_mstData(mstData), .o_mstBoffs(mstBoffs), .o_mstUser(mstUser),
      .o_mstLrdy(mstLrdy), .i_mstRValid(mstRValid), .i_mstRData(mstRData), .i_mstROpc(mstROpc)
   );

   int errors = 0;
   int checks = 0;
   int modelIssues = 0;
   int dutIssues = 0;

   // Model: which channels hold a parked request, and whether a wide access
   // has been granted and still awaits its response.
   logic [NB-1:0]  mHeld = '0;
   bit             mOut = 1'b0;
   logic [AW-1:0]  mAdd  [NB];
   logic           mWen  [NB];
   logic [BWIN-1:0] mBe  [NB];
   logic [DWIN-1:0] mData[NB];

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic post(input int ch, input logic [AW-1:0] a, input logic w,
                       input logic [BWIN-1:0] b, input logic [DWIN-1:0] d);
      slvAdd[ch]  = a;
      slvWen[ch]  = w;
      slvBe[ch]   = b;
      slvData[ch] = d;
      slvReq[ch]  = 1'b1;
   endtask

   // One clock: compare all outputs at the falling edge, then advance the model.
   task automatic applyStimulus(input string tag);
      logic [NB-1:0]   expGnt;
      logic [NB-1:0]   expRValid;
      logic [NB-1:0]   nHeld;
      logic [NB-1:0]   acc;
      logic [DW-1:0]   expData;
      logic [DW/8-1:0] expBe;
      logic            expReq;
      logic            expLrdy;
      bit              nOut;
      @(negedge clk);
      if (!rstN) begin
         mHeld = '0;
         mOut  = 1'b0;
      end
      expGnt    = ~mHeld;
      expReq    = (&mHeld) & !mOut;
      expRValid = {NB{mOut & mstRValid}};
      expLrdy   = &slvLrdy;
      checkOutput({tag, ".gnt"}, slvGnt, expGnt);
      checkOutput({tag, ".req"}, mstReq, expReq);
      checkOutput({tag, ".rvalid"}, slvRValid, expRValid);
      checkOutput({tag, ".rdata0"}, slvRData[0], mstRData[31:0]);
      checkOutput({tag, ".rdata1"}, slvRData[1], mstRData[63:32]);
      checkOutput({tag, ".ropc"}, {slvROpc[1], slvROpc[0]}, {mstROpc, mstROpc});
      checkOutput({tag, ".lrdy"}, mstLrdy, expLrdy);
      checkOutput({tag, ".zeros"}, {slvRUser, mstUser, mstBoffs}, 64'd0);
      if (expReq) begin
         expData = {mData[1], mData[0]};
         expBe   = {mBe[1], mBe[0]};
         checkOutput({tag, ".add"}, mstAdd, mAdd[0]);
         checkOutput({tag, ".wen"}, mstWen, mWen[0]);
         checkOutput({tag, ".be"}, mstBe, expBe);
         checkOutput({tag, ".data"}, mstData, expData);
      end
      if (mstReq && mstGnt) dutIssues++;
      nHeld = mHeld;
      nOut  = mOut;
      acc   = '0;
      if (!rstN || clear) begin
         nHeld = '0;
         nOut  = 1'b0;
      end else if (expReq && mstGnt) begin
         nHeld = '0;
         nOut  = 1'b1;
         modelIssues++;
      end else begin
         if (mOut && mstRValid) nOut = 1'b0;
         for (int i = 0; i < NB; i++) begin
            if (slvReq[i] && !mHeld[i]) begin
               nHeld[i] = 1'b1;
               acc[i]   = 1'b1;
               mAdd[i]  = slvAdd[i];
               mWen[i]  = slvWen[i];
               mBe[i]   = slvBe[i];
               mData[i] = slvData[i];
            end
         end
      end
      @(posedge clk);
      #1;
      mHeld  = nHeld;
      mOut   = nOut;
      slvReq = slvReq & ~acc;
   endtask

   initial begin
      for (int i = 0; i < NB; i++) begin
         mAdd[i] = '0; mWen[i] = 1'b0; mBe[i] = '0; mData[i] = '0;
      end
      rstN = 1'b0; clear = 1'b0; slvReq = '0; slvAdd = '0; slvWen = '0; slvBe = '0;
      slvData = '0; slvLrdy = '1; mstGnt = 1'b0; mstRValid = 1'b0; mstRData = '0; mstROpc = '0;
      applyStimulus("rst0");
      checkOutput("rst.gntAll", slvGnt, 2'b11);
      applyStimulus("rst1");
      rstN = 1'b1;
      applyStimulus("rst2");
      checkOutput("rst.reqLow", mstReq, 1'b0);

      // Both channels write together; wide access appears the next cycle.
      post(0, 32'h100, 1'b0, 4'hF, 32'hAAAA_AAAA);
      post(1, 32'h104, 1'b0, 4'hF, 32'h5555_5555);
      applyStimulus("w.c0");
      checkOutput("w.req", mstReq, 1'b1);
      checkOutput("w.add", mstAdd, 32'h100);
      checkOutput("w.data", mstData, 64'h5555_5555_AAAA_AAAA);
      checkOutput("w.be", mstBe, 8'hFF);
      mstGnt = 1'b1;
      applyStimulus("w.c1");
      mstGnt = 1'b0; mstRValid = 1'b1; mstRData = 64'h0123_4567_89AB_CDEF;
      applyStimulus("w.c2");
      mstRValid = 1'b0;

      // Staggered reads: channel 0 waits until channel 1 arrives.
      post(0, 32'h200, 1'b1, 4'hF, 32'h0);
      applyStimulus("r.c0");
      for (int c = 1; c <= 3; c++) begin
         checkOutput("r.gnt0Low", slvGnt[0], 1'b0);
         checkOutput("r.reqLow", mstReq, 1'b0);
         if (c == 3) post(1, 32'h204, 1'b1, 4'hF, 32'h0);
         applyStimulus("r.wait");
      end
      checkOutput("r.reqC4", mstReq, 1'b1);
      mstGnt = 1'b1;
      applyStimulus("r.gnt");
      mstGnt = 1'b0; mstRValid = 1'b1; mstRData = 64'h1111_2222_3333_4444;
      #1;
      checkOutput("r.rvalidBoth", slvRValid, 2'b11);
      checkOutput("r.slice0", slvRData[0], 32'h3333_4444);
      checkOutput("r.slice1", slvRData[1], 32'h1111_2222);
      applyStimulus("r.resp");
      mstRValid = 1'b0;

      // Stalled issue: request and payload must hold while gnt is low.
      post(0, 32'h300, 1'b0, 4'h3, 32'hDEAD_BEEF);
      post(1, 32'h304, 1'b0, 4'hC, 32'hCAFE_F00D);
      applyStimulus("s.c0");
      for (int c = 0; c < 5; c++) begin
         checkOutput("s.req", mstReq, 1'b1);
         checkOutput("s.add", mstAdd, 32'h300);
         checkOutput("s.data", mstData, 64'hCAFE_F00D_DEAD_BEEF);
         checkOutput("s.gntLow", slvGnt, 2'b00);
         applyStimulus("s.stall");
      end
      mstGnt = 1'b1;
      applyStimulus("s.gnt");
      mstGnt = 1'b0; mstRValid = 1'b1;
      applyStimulus("s.resp");
      mstRValid = 1'b0;

      // Next round parked during a slow response.
      post(0, 32'h400, 1'b0, 4'hF, 32'h1);
      post(1, 32'h404, 1'b0, 4'hF, 32'h2);
      applyStimulus("n.c0");
      mstGnt = 1'b1;
      applyStimulus("n.gnt");
      mstGnt = 1'b0;
      post(0, 32'h500, 1'b0, 4'hF, 32'h3);
      post(1, 32'h504, 1'b0, 4'hF, 32'h4);
      applyStimulus("n.park");
      for (int c = 0; c < 3; c++) begin
         checkOutput("n.reqHeld", mstReq, 1'b0);
         applyStimulus("n.delay");
      end
      mstRValid = 1'b1;
      applyStimulus("n.resp");
      mstRValid = 1'b0;
      checkOutput("n.reqNext", mstReq, 1'b1);
      checkOutput("n.add2", mstAdd, 32'h500);
      mstGnt = 1'b1;
      applyStimulus("n.gnt2");
      mstGnt = 1'b0; mstRValid = 1'b1;
      applyStimulus("n.resp2");
      mstRValid = 1'b0;

      // Clear while a response is pending drops that response.
      post(0, 32'h600, 1'b1, 4'hF, 32'h0);
      post(1, 32'h604, 1'b1, 4'hF, 32'h0);
      applyStimulus("c.c0");
      mstGnt = 1'b1;
      applyStimulus("c.gnt");
      mstGnt = 1'b0; clear = 1'b1;
      applyStimulus("c.clear");
      clear = 1'b0; mstRValid = 1'b1;
      #1;
      checkOutput("c.noRValid", slvRValid, 2'b00);
      checkOutput("c.gntAll", slvGnt, 2'b11);
      applyStimulus("c.late");
      mstRValid = 1'b0;
      checkOutput("c.reqLow", mstReq, 1'b0);

      // Random traffic.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NB; i++) begin
            if (!slvReq[i] && ($urandom_range(0, 9) < 4))
               post(i, $urandom, 1'($urandom), 4'($urandom), $urandom);
         end
         mstGnt    = 1'($urandom);
         mstRValid = ($urandom_range(0, 2) == 0);
         mstRData  = {$urandom, $urandom};
         mstROpc   = 1'($urandom);
         slvLrdy   = 2'($urandom);
         clear     = ($urandom_range(0, 59) == 0);
         applyStimulus("rnd");
      end
      clear = 1'b0; mstGnt = 1'b1; mstRValid = 1'b1;
      for (int c = 0; c < 10; c++) applyStimulus("drain");
      checkOutput("issueCount", 64'(dutIssues), 64'(modelIssues));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hci_core_merge.md
HCI_CORE_MERGE -- requirements
Module: hci_core_merge

Interface
REQ-001 Parameter DW, default 64, data width of the wide master port in bits.
REQ-002 Parameter NB_IN_CHAN, default 2, number of narrow slave ports; derived DW_IN = DW/NB_IN_CHAN, BW_IN = DW_IN/8; DW SHALL be a multiple of 8*NB_IN_CHAN.
REQ-003 Port clk_i, input, 1, the only clock; all state on rising edge.
REQ-004 Port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 Port clear_i, input, 1, synchronous clear; same effect as reset; higher priority than all other updates.
REQ-006 Port tcdm_slave[NB_IN_CHAN-1:0], hci_core_intf.slave, data DW_IN, narrow requesters; slice i carries bits [(i+1)*DW_IN-1:i*DW_IN] of the merged word.
REQ-007 Port tcdm_master, hci_core_intf.master, data DW, single wide memory-side port.

Function
REQ-008 Each slave channel i SHALL own a one-entry buffer (add, wen, be, data) with a valid flag full[i].
REQ-009 tcdm_slave[i].gnt SHALL equal ~full[i]; on req & gnt the buffer SHALL capture the request and set full[i] at the next edge.
REQ-010 FSM states: COLLECT, ISSUE, RESP; reset state COLLECT.
REQ-011 COLLECT -> ISSUE when all full[] bits will be set at the next edge.
REQ-012 In ISSUE, tcdm_master.req SHALL be 1. tcdm_master.add SHALL be buffer 0 add. tcdm_master.wen SHALL be buffer 0 wen. tcdm_master.data and be SHALL be the concatenation of buffers, channel 0 in the LSBs.
REQ-013 tcdm_master.req SHALL be 0 in COLLECT and RESP.
REQ-014 ISSUE with tcdm_master.gnt=1 -> RESP; all full[] bits SHALL clear at the same edge; slave gnt SHALL NOT be bypassed in that cycle.
REQ-015 In RESP, buffers SHALL keep accepting the next round of requests.
REQ-016 RESP with tcdm_master.r_valid=1: -> ISSUE if all full[] will be set at the next edge, else -> COLLECT.
REQ-017 tcdm_slave[i].r_valid SHALL equal tcdm_master.r_valid & (state==RESP), combinationally; r_valid outside RESP SHALL be ignored.
REQ-018 tcdm_slave[i].r_data SHALL be tcdm_master.r_data slice i, combinationally.
REQ-019 tcdm_slave[i].r_opc SHALL be tcdm_master.r_opc.
REQ-020 Exactly one wide transaction SHALL be outstanding at a time.
REQ-021 tcdm_master.lrdy SHALL be the AND of all tcdm_slave[i].lrdy.
REQ-022 The following SHALL be '0: tcdm_master.user, tcdm_master.boffs, all tcdm_slave[i].r_user.
REQ-023 Channel wen/add mismatches SHALL NOT be checked; channel 0 values win.
REQ-024 Minimum latency: all slaves req in cycle 0 -> master req in cycle 1; gnt in cycle 1 with r_valid in cycle 2 -> slave r_valid in cycle 2 and new slave capture allowed in cycle 2.

Reset
REQ-025 On rst_ni low or clear_i high, the block SHALL: set state to COLLECT, clear all full[], clear all buffer contents to 0.
REQ-026 Output values during and after reset: tcdm_master.req=0, all tcdm_slave[i].gnt=1, all tcdm_slave[i].r_valid=0.
REQ-027 Reset or clear in RESP SHALL drop the pending response; a later master r_valid SHALL NOT reach the slaves.

Verification
REQ-028 Setup DW=64, NB_IN_CHAN=2. Stimulus: both slaves write in cycle 0 with add 0x100/0x104, data 0xAAAA_AAAA/0x5555_5555, be 0xF/0xF; master gnt in cycle 1. Expected: master req in cycle 1, add 0x100, data 0x5555_5555_AAAA_AAAA, be 0xFF.
REQ-029 Stimulus: slave 0 reads in cycle 0, slave 1 reads in cycle 3. Expected: slave0 gnt=0 in cycles 1-3, master req first in cycle 4; master r_data 0x1111_2222_3333_4444 returns 0x3333_4444 to slave 0 and 0x1111_2222 to slave 1, both with r_valid in the same cycle.
REQ-030 Stimulus: hold master gnt=0 for 5 cycles in ISSUE. Expected: master req, add and data stable; both slave gnt=0 throughout.
REQ-031 Stimulus: send the next round during RESP and delay r_valid 3 cycles. Expected: master req stays 0 until r_valid, goes to 1 in the following cycle, and no transaction is lost.
REQ-032 Stimulus: clear_i pulse in RESP, then master r_valid the next cycle. Expected: slave r_valid stays 0, state returns to COLLECT, all gnt=1.
